ddr2_init_engine: RTL and testbench

- Power-up and initialisation sequencer for the DDR2 controller. Sits directly upstream of Processing_logic and produces its `ready` input.
- After reset it walks the JEDEC DDR2 init sequence on the SDRAM command bus: CKE, NOP, PRECHARGE ALL, EMRS2/3/1, MRS, REFRESH x2, OCD.
- When the sequence completes it asserts `ready` and holds it. The top level then muxes the command bus from this block to Processing_logic, using `ready` as the select.

---
 rtl/ddr2_pkg.sv | 53 +++++
 rtl/ddr2_init_engine_if.sv | 21 ++
 rtl/ddr2_init_rom.sv | 61 ++++++
 rtl/ddr2_init_engine.sv | 117 +++++++++++
 tb/tb_ddr2_init_engine.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ddr2_pkg.sv
// Shared DDR2 definitions: command encodings, mode-register field offsets,
// init step indices and the burst-length encoder.
package ddr2_pkg;

    // SDRAM commands as {cs_bar, ras_bar, cas_bar, we_bar}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PREA = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;

    // Mode-register / extended-mode-register field offsets
    localparam int unsigned MR_BL_LSB   = 0;
    localparam int unsigned MR_BT_BIT   = 3;
    localparam int unsigned MR_CL_LSB   = 4;
    localparam int unsigned MR_DLL_RST  = 8;
    localparam int unsigned MR_WR_LSB   = 9;
    localparam int unsigned EMR_AL_LSB  = 3;
    localparam int unsigned EMR_OCD_LSB = 7;
    localparam int unsigned A_PREA_BIT  = 10;

    // Init sequence step indices
    typedef enum logic [3:0] {
        STEP_PWRUP      = 4'd0,
        STEP_NOP400     = 4'd1,
        STEP_PREA0      = 4'd2,
        STEP_EMRS2      = 4'd3,
        STEP_EMRS3      = 4'd4,
        STEP_EMRS1_DLL  = 4'd5,
        STEP_MRS_DLLRST = 4'd6,
        STEP_PREA1      = 4'd7,
        STEP_REF0       = 4'd8,
        STEP_REF1       = 4'd9,
        STEP_MRS        = 4'd10,
        STEP_OCD_DFLT   = 4'd11,
        STEP_OCD_EXIT   = 4'd12,
        STEP_DLL_WAIT   = 4'd13,
        STEP_DONE       = 4'd14
    } step_e;

    // Burst length to MR code; anything other than 4 encodes as burst of 8
    function automatic logic [2:0] bl_code(input logic [3:0] bl);
        logic [2:0] code;
        case (bl)
            4'd4:    code = 3'b010;
            default: code = 3'b011;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ddr2_init_engine_if.sv
// SDRAM command bus plus ready/debug outputs of the init engine.
interface ddr2_init_engine_if;
    logic        ready;
    logic        cke;
    logic        cs_bar;
    logic        ras_bar;
    logic        cas_bar;
    logic        we_bar;
    logic [1:0]  BA;
    logic [12:0] A;
    logic        ODT;
    logic [3:0]  init_step;

    modport master (
        output ready, cke, cs_bar, ras_bar, cas_bar, we_bar, BA, A, ODT, init_step
    );

    modport slave (
        input ready, cke, cs_bar, ras_bar, cas_bar, we_bar, BA, A, ODT, init_step
    );
endinterface

// File: rtl/ddr2_init_rom.sv
// Combinational step table: step index -> command, BA, A, wait length, CKE.
module ddr2_init_rom
    import ddr2_pkg::*;
#(
    parameter logic [3:0]  BL       = 4'b1000,
    parameter logic        BT       = 1'b0,
    parameter logic [2:0]  CL       = 3'b011,
    parameter logic [2:0]  AL       = 3'b001,
    parameter logic [2:0]  WR       = 3'd3,
    parameter int unsigned T_PWRUP  = 100,
    parameter int unsigned T_NOP400 = 40,
    parameter int unsigned T_RP     = 8,
    parameter int unsigned T_MRD    = 4,
    parameter int unsigned T_RFC    = 42,
    parameter int unsigned T_DLL    = 400
) (
    input  step_e        i_step,
    output logic [3:0]   o_cmd,
    output logic [1:0]   o_ba,
    output logic [12:0]  o_a,
    output logic [15:0]  o_wait,
    output logic         o_cke
);

    localparam logic [12:0] A_PREA     = 13'(1) << A_PREA_BIT;
    localparam logic [12:0] A_EMRS1    = 13'(AL) << EMR_AL_LSB;
    localparam logic [12:0] A_OCD_DFLT = A_EMRS1 | (13'b111 << EMR_OCD_LSB);
    localparam logic [12:0] A_MRS      = (13'(WR - 3'd1) << MR_WR_LSB)
                                       | (13'(CL) << MR_CL_LSB)
                                       | (13'(BT) << MR_BT_BIT)
                                       | (13'(bl_code(BL)) << MR_BL_LSB);
    localparam logic [12:0] A_MRS_DLL  = A_MRS | (13'(1) << MR_DLL_RST);

    // Table lookup for the current step
    always_comb begin
        o_cmd  = CMD_NOP;
        o_ba   = 2'b00;
        o_a    = '0;
        o_wait = 16'd1;
        o_cke  = 1'b1;
        case (i_step)
            STEP_PWRUP:      begin o_cke = 1'b0; o_wait = 16'(T_PWRUP); end
            STEP_NOP400:     o_wait = 16'(T_NOP400);
            STEP_PREA0:      begin o_cmd = CMD_PREA; o_a = A_PREA; o_wait = 16'(T_RP); end
            STEP_EMRS2:      begin o_cmd = CMD_MRS; o_ba = 2'b10; o_wait = 16'(T_MRD); end
            STEP_EMRS3:      begin o_cmd = CMD_MRS; o_ba = 2'b11; o_wait = 16'(T_MRD); end
            STEP_EMRS1_DLL:  begin o_cmd = CMD_MRS; o_ba = 2'b01; o_a = A_EMRS1; o_wait = 16'(T_MRD); end
            STEP_MRS_DLLRST: begin o_cmd = CMD_MRS; o_a = A_MRS_DLL; o_wait = 16'(T_MRD); end
            STEP_PREA1:      begin o_cmd = CMD_PREA; o_a = A_PREA; o_wait = 16'(T_RP); end
            STEP_REF0:       begin o_cmd = CMD_REF; o_wait = 16'(T_RFC); end
            STEP_REF1:       begin o_cmd = CMD_REF; o_wait = 16'(T_RFC); end
            STEP_MRS:        begin o_cmd = CMD_MRS; o_a = A_MRS; o_wait = 16'(T_MRD); end
            STEP_OCD_DFLT:   begin o_cmd = CMD_MRS; o_ba = 2'b01; o_a = A_OCD_DFLT; o_wait = 16'(T_MRD); end
            STEP_OCD_EXIT:   begin o_cmd = CMD_MRS; o_ba = 2'b01; o_a = A_EMRS1; o_wait = 16'(T_MRD); end
            STEP_DLL_WAIT:   o_wait = 16'(T_DLL);
            STEP_DONE:       o_wait = 16'd1;
            default:         o_wait = 16'd1;
        endcase
    end

endmodule

// File: rtl/ddr2_init_engine.sv
// DDR2 power-up/initialisation sequencer. Walks the step table, drives each
// command for CMD_HOLD cycles followed by NOP, then asserts a sticky ready.
module ddr2_init_engine
    import ddr2_pkg::*;
#(
    parameter logic [3:0]  BL       = 4'b1000,
    parameter logic        BT       = 1'b0,
    parameter logic [2:0]  CL       = 3'b011,
    parameter logic [2:0]  AL       = 3'b001,
    parameter logic [2:0]  WR       = 3'd3,
    parameter int unsigned CMD_HOLD = 2,
    parameter int unsigned T_PWRUP  = 100,
    parameter int unsigned T_NOP400 = 40,
    parameter int unsigned T_RP     = 8,
    parameter int unsigned T_MRD    = 4,
    parameter int unsigned T_RFC    = 42,
    parameter int unsigned T_DLL    = 400
) (
    input  logic               clk,
    input  logic               reset,
    ddr2_init_engine_if.master bus
);

    localparam logic [15:0] CMD_HOLD_W = 16'(CMD_HOLD);

    step_e       r_state;
    step_e       w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_last;
    logic [3:0]  w_rom_cmd;
    logic [1:0]  w_rom_ba;
    logic [12:0] w_rom_a;
    logic [15:0] w_rom_wait;
    logic        w_rom_cke;
    logic [3:0]  w_cmd;
    logic        w_ready;

    ddr2_init_rom #(
        .BL       (BL),
        .BT       (BT),
        .CL       (CL),
        .AL       (AL),
        .WR       (WR),
        .T_PWRUP  (T_PWRUP),
        .T_NOP400 (T_NOP400),
        .T_RP     (T_RP),
        .T_MRD    (T_MRD),
        .T_RFC    (T_RFC),
        .T_DLL    (T_DLL)
    ) u_rom (
        .i_step (r_state),
        .o_cmd  (w_rom_cmd),
        .o_ba   (w_rom_ba),
        .o_a    (w_rom_a),
        .o_wait (w_rom_wait),
        .o_cke  (w_rom_cke)
    );

    // Step index and in-step cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STEP_PWRUP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Advance after W cycles in a step; DONE is terminal, counter saturates
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last      = (r_cnt >= (w_rom_wait - 16'd1));
        if ((r_state != STEP_DONE) && w_last) begin
            w_state_nxt = step_e'(r_state + 4'd1);
            w_cnt_nxt   = '0;
        end else if (r_cnt != '1) begin
            w_cnt_nxt   = r_cnt + 16'd1;
        end
    end

    // Command for the first CMD_HOLD cycles of a step, NOP afterwards
    always_comb begin
        w_cmd   = (r_cnt < CMD_HOLD_W) ? w_rom_cmd : CMD_NOP;
        w_ready = (r_state == STEP_DONE);
    end

    // Registered bus outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.cke       <= 1'b0;
            bus.cs_bar    <= 1'b0;
            bus.ras_bar   <= 1'b1;
            bus.cas_bar   <= 1'b1;
            bus.we_bar    <= 1'b1;
            bus.BA        <= '0;
            bus.A         <= '0;
            bus.ODT       <= 1'b0;
            bus.ready     <= 1'b0;
            bus.init_step <= '0;
        end else begin
            bus.cke       <= w_rom_cke;
            bus.cs_bar    <= w_cmd[3];
            bus.ras_bar   <= w_cmd[2];
            bus.cas_bar   <= w_cmd[1];
            bus.we_bar    <= w_cmd[0];
            bus.BA        <= w_rom_ba;
            bus.A         <= w_rom_a;
            bus.ODT       <= 1'b0;
            bus.ready     <= w_ready;
            bus.init_step <= r_state;
        end
    end

endmodule

// File: tb/tb_ddr2_init_engine.sv
// Bench for ddr2_init_engine: timeline model from the step table, per-cycle
// comparison of two instances (default and overridden mode parameters),
// randomized abort points, command-order log and hand-computed pins.
module tb_ddr2_init_engine;
    import ddr2_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ddr2_init_engine_if bus_d();
    ddr2_init_engine_if bus_o();

    ddr2_init_engine u_def (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_d)
    );

    ddr2_init_engine #(
        .BL (4'b0100),
        .CL (3'd4),
        .AL (3'd0)
    ) u_ovr (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus_o)
    );

    int checks = 0;
    int errors = 0;
    int nedges = 0;

    // Vector layout: [25] cke, [24:21] cmd, [20:19] BA, [18:6] A, [5] ODT, [4] ready, [3:0] step
    logic [25:0] act_d, act_o;
    assign act_d = {bus_d.cke, bus_d.cs_bar, bus_d.ras_bar, bus_d.cas_bar, bus_d.we_bar,
                    bus_d.BA, bus_d.A, bus_d.ODT, bus_d.ready, bus_d.init_step};
    assign act_o = {bus_o.cke, bus_o.cs_bar, bus_o.ras_bar, bus_o.cas_bar, bus_o.we_bar,
                    bus_o.BA, bus_o.A, bus_o.ODT, bus_o.ready, bus_o.init_step};

    localparam logic [25:0] RESET_V = {1'b0, 4'b0111, 2'b00, 13'h0000, 1'b0, 1'b0, 4'h0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) nedges <= 0;
        else        nedges <= nedges + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int wait_of(input int k);
        case (k)
            0: return 100;
            1: return 40;
            2, 7: return 8;
            8, 9: return 42;
            13: return 400;
            default: return 4;
        endcase
    endfunction

    // Expected outputs after edge number pos since reset release
    function automatic logic [25:0] model(input int pos, input int bl, input int cl, input int al);
        int start = 0;
        int s = 14;
        int off = 0;
        int blc;
        int mr;
        logic [3:0]  c;
        logic [1:0]  ba;
        logic [12:0] a;
        blc = (bl == 4) ? 2 : 3;
        mr  = (3 - 1) * 512 + cl * 16 + blc;
        for (int k = 0; k < 14; k++) begin
            if (s == 14 && pos < start + wait_of(k)) begin
                s   = k;
                off = pos - start;
            end
            start += wait_of(k);
        end
        c = 4'b0111; ba = 2'd0; a = 13'd0;
        case (s)
            2, 7:  begin c = 4'b0010; a = 13'h0400; end
            3:     begin c = 4'b0000; ba = 2'd2; end
            4:     begin c = 4'b0000; ba = 2'd3; end
            5:     begin c = 4'b0000; ba = 2'd1; a = 13'(al * 8); end
            6:     begin c = 4'b0000; a = 13'(mr + 256); end
            8, 9:  c = 4'b0001;
            10:    begin c = 4'b0000; a = 13'(mr); end
            11:    begin c = 4'b0000; ba = 2'd1; a = 13'(896 + al * 8); end
            12:    begin c = 4'b0000; ba = 2'd1; a = 13'(al * 8); end
            default: ;
        endcase
        if (off >= 2) c = 4'b0111;
        return {(s != 0), c, ba, a, 1'b0, (s == 14), 4'(s)};
    endfunction

    typedef struct {
        logic [3:0]  c;
        logic [1:0]  ba;
        logic [12:0] a;
        int          pos;
    } ent_t;
    ent_t log_q[$];

    // Per-cycle comparison against the model, plus logging of command starts
    initial begin
        int pos;
        logic [3:0] prev_cmd;
        prev_cmd = 4'b0111;
        forever begin
            @(negedge clk);
            pos = (nedges > 0) ? nedges - 1 : 0;
            if (!rst_n) pos = 0;
            chk($sformatf("def_pos%0d", pos), 32'(act_d), 32'(model(pos, 8, 3, 1)));
            chk($sformatf("ovr_pos%0d", pos), 32'(act_o), 32'(model(pos, 4, 4, 0)));
            if (!rst_n) begin
                log_q.delete();
                prev_cmd = 4'b0111;
            end else begin
                if (act_d[24:21] != 4'b0111 && prev_cmd == 4'b0111)
                    log_q.push_back('{c: act_d[24:21], ba: act_d[20:19], a: act_d[18:6], pos: pos});
                prev_cmd = act_d[24:21];
            end
        end
    end

    int exp_pos [11] = '{140, 148, 152, 156, 160, 164, 172, 214, 256, 260, 264};
    int exp_cmd [11] = '{2, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0};
    int exp_ba  [11] = '{0, 2, 3, 1, 0, 0, 0, 0, 0, 1, 1};
    int exp_a   [11] = '{'h400, 0, 0, 'h008, 'h533, 'h400, 0, 0, 'h433, 'h388, 'h008};

    task automatic abort_after(input int k);
        repeat (k + 1) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk($sformatf("async_def_k%0d", k), 32'(act_d), 32'(RESET_V));
        chk($sformatf("async_ovr_k%0d", k), 32'(act_o), 32'(RESET_V));
        repeat ($urandom_range(1, 4)) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        logic [25:0] m;
        // Model pins from hand-computed values
        m = model(99, 8, 3, 1);   chk("pin_cke99",  32'(m[25]), 32'd0);
        m = model(100, 8, 3, 1);  chk("pin_cke100", 32'(m[25]), 32'd1);
        m = model(140, 8, 3, 1);  chk("pin_prea140", 32'({m[24:21], m[18:6]}), 32'({4'b0010, 13'h0400}));
        m = model(141, 8, 3, 1);  chk("pin_prea141", 32'(m[24:21]), 32'(4'b0010));
        m = model(142, 8, 3, 1);  chk("pin_nop142", 32'(m[24:21]), 32'(4'b0111));
        m = model(160, 8, 3, 1);  chk("pin_mrs160", 32'(m[18:6]), 32'h0533);
        m = model(256, 8, 3, 1);  chk("pin_mrs256", 32'(m[18:6]), 32'h0433);
        m = model(260, 8, 3, 1);  chk("pin_ocd260", 32'(m[18:6]), 32'h0388);
        m = model(667, 8, 3, 1);  chk("pin_rdy667", 32'(m[4]), 32'd0);
        m = model(668, 8, 3, 1);  chk("pin_rdy668", 32'(m[4]), 32'd1);
        m = model(160, 4, 4, 0);  chk("pin_ovr_mrs", 32'(m[18:6]), 32'h0542);
        m = model(156, 4, 4, 0);  chk("pin_ovr_emrs1", 32'(m[18:6]), 32'h0000);

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("reset_def", 32'(act_d), 32'(RESET_V));
        chk("reset_ovr", 32'(act_o), 32'(RESET_V));

        // Full default sequence and command order
        @(negedge clk) rst_n = 1'b1;
        repeat (720) @(posedge clk);
        @(negedge clk);
        chk("log_size", 32'(log_q.size()), 32'd11);
        for (int i = 0; i < 11 && i < log_q.size(); i++) begin
            chk($sformatf("log%0d_pos", i), 32'(log_q[i].pos), 32'(exp_pos[i]));
            chk($sformatf("log%0d_cmd", i), 32'(log_q[i].c),   32'(exp_cmd[i]));
            chk($sformatf("log%0d_ba", i),  32'(log_q[i].ba),  32'(exp_ba[i]));
            chk($sformatf("log%0d_a", i),   32'(log_q[i].a),   32'(exp_a[i]));
        end

        // Abort after ready, then at edge 200, then at random points
        abort_after(0);
        abort_after(200);
        for (int i = 0; i < 3; i++) abort_after(int'($urandom_range(1, 750)));

        // Full sequence again and a long hold after ready
        repeat (670 + 1000) @(posedge clk);
        @(negedge clk);
        chk("hold_ready", 32'(bus_d.ready), 32'd1);
        chk("hold_step",  32'(bus_d.init_step), 32'd14);
        chk("hold_nop",   32'({bus_d.cs_bar, bus_d.ras_bar, bus_d.cas_bar, bus_d.we_bar}), 32'(4'b0111));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
